// File: rtl/cry_rgb_lookup_seq.sv
// CRY-to-RGB sequencer: three lookups (R, G, B tables) through one shared
// 1-cycle registered colour ROM port, each result optionally scaled by Y.
module cry_rgb_lookup_seq #(
  parameter bit SCALE_EN = 1'b1
) (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_cry,
  output logic [9:0]  rom_addr,
  input  logic [7:0]  rom_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a held result stays stable.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A_R  = 3'd1,
    A_G  = 3'd2,
    C_R  = 3'd3,
    C_G  = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  idx_q;
  logic [7:0]  y_q;
  logic        accept;
  logic [15:0] prod;
  logic [7:0]  scaled;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign accept    = in_valid && in_ready;

  // (Y + 1) spans 1..256, so Y = 0xFF passes the table value through exactly.
  assign prod   = {8'd0, rom_q} * ({8'd0, y_q} + 16'd1);
  assign scaled = SCALE_EN ? prod[15:8] : rom_q;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = A_R;
      A_R:     state_nxt = A_G;
      A_G:     state_nxt = C_R;
      C_R:     state_nxt = C_G;
      C_G:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rom_q lags rom_addr by one edge, so each capture happens one state after
  // the matching address was issued.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      idx_q     <= 8'd0;
      y_q       <= 8'd0;
      rom_addr  <= 10'd0;
      out_valid <= 1'b0;
      out_r     <= 8'd0;
      out_g     <= 8'd0;
      out_b     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q    <= in_cry[15:8];
            y_q      <= in_cry[7:0];
            rom_addr <= {2'd0, in_cry[15:8]};
          end
        end
        A_R: rom_addr <= {2'd1, idx_q};
        A_G: begin
          out_r    <= scaled;
          rom_addr <= {2'd2, idx_q};
        end
        C_R: out_g <= scaled;
        C_G: begin
          out_b     <= scaled;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cry_rgb_lookup_seq.sv
// Bench for cry_rgb_lookup_seq: scaled and raw instances share one stimulus
// stream; results are checked against a table/arithmetic model.
module tb_cry_rgb_lookup_seq;

  logic        sys_clk;
  logic        resetl;
  logic        in_valid;
  logic [15:0] in_cry;
  logic        out_ready;

  logic        in_ready,  in_ready_raw;
  logic [9:0]  rom_addr,  rom_addr_raw;
  logic [7:0]  rom_q,     rom_q_raw;
  logic        out_valid, out_valid_raw;
  logic [7:0]  out_r, out_g, out_b;
  logic [7:0]  raw_r, raw_g, raw_b;
  logic        busy, busy_raw;
  logic [2:0]  dbg_state, dbg_state_raw;

  int total = 0;
  int bad   = 0;
  int busy_cnt = 0;
  int n_acc = 0;
  int n_done = 0;
  logic accepted;
  logic [23:0] exp_q[$];
  logic [23:0] exp_raw_q[$];

  cry_rgb_lookup_seq #(.SCALE_EN(1'b1)) u_dut (
    .sys_clk(sys_clk), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready),
    .in_cry(in_cry), .rom_addr(rom_addr), .rom_q(rom_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .busy(busy), .dbg_state(dbg_state)
  );

  cry_rgb_lookup_seq #(.SCALE_EN(1'b0)) u_raw (
    .sys_clk(sys_clk), .resetl(resetl), .in_valid(in_valid), .in_ready(in_ready_raw),
    .in_cry(in_cry), .rom_addr(rom_addr_raw), .rom_q(rom_q_raw), .out_valid(out_valid_raw),
    .out_ready(out_ready), .out_r(raw_r), .out_g(raw_g), .out_b(raw_b),
    .busy(busy_raw), .dbg_state(dbg_state_raw)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] rom_lookup(input logic [9:0] a);
    logic [7:0] i;
    i = a[7:0];
    case (a[9:8])
      2'd0:    return i;
      2'd1:    return ~i;
      2'd2:    return i ^ 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge sys_clk) begin
    rom_q     <= rom_lookup(rom_addr);
    rom_q_raw <= rom_lookup(rom_addr_raw);
  end

  // Reference: R = idx, G = 255 - idx, B = idx xor 0x5A, scaled by (Y+1)/256.
  function automatic logic [23:0] model(input logic [15:0] cry, input bit scale);
    int idx;
    int y;
    int lut[3];
    int c[3];
    idx = int'(cry[15:8]);
    y   = int'(cry[7:0]);
    lut[0] = idx;
    lut[1] = 255 - idx;
    lut[2] = idx ^ 'h5A;
    for (int k = 0; k < 3; k++) c[k] = scale ? (lut[k] * (y + 1)) / 256 : lut[k];
    return {c[0][7:0], c[1][7:0], c[2][7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver + scoreboard: inputs change at the falling edge, handshakes are
  // evaluated on the values the next rising edge will sample.
  task automatic cycle(input logic iv, input logic [15:0] cry, input logic ordy);
    @(negedge sys_clk);
    in_valid  = iv;
    in_cry    = cry;
    out_ready = ordy;
    #1;
    if (busy) busy_cnt++;
    accepted = in_valid && in_ready;
    if (accepted) begin
      exp_q.push_back(model(cry, 1'b1));
      exp_raw_q.push_back(model(cry, 1'b0));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      else chk("sb_rgb", {8'd0, out_r, out_g, out_b}, {8'd0, exp_q.pop_front()});
      n_done++;
    end
    if (out_valid_raw && out_ready) begin
      if (exp_raw_q.size() == 0) chk("sb_raw_underflow", 32'(exp_raw_q.size()), 32'd1);
      else chk("sb_raw_rgb", {8'd0, raw_r, raw_g, raw_b}, {8'd0, exp_raw_q.pop_front()});
    end
  endtask

  task automatic run_pixel(input logic [15:0] cry);
    cycle(1'b1, cry, 1'b1);
    for (int k = 0; k < 6; k++) cycle(1'b0, 16'h0000, 1'b1);
  endtask

  initial begin : main
    int acc0;
    int cyc;
    int sent;
    logic [15:0] cur;

    resetl = 1'b0; in_valid = 1'b0; in_cry = 16'h0000; out_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge sys_clk);
    resetl = 1'b1;

    // basic: address sequence, latency, busy span
    busy_cnt = 0;
    cycle(1'b1, 16'h3CFF, 1'b1);
    chk("basic_accept", 32'(accepted), 32'd1);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("basic_addr_r", 32'(rom_addr), 32'h03C);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("basic_addr_g", 32'(rom_addr), 32'h13C);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("basic_addr_b", 32'(rom_addr), 32'h23C);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("basic_not_yet_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("basic_valid_lat4", 32'(out_valid), 32'd1);
    chk("basic_rgb", {8'd0, out_r, out_g, out_b}, 32'h3CC366);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("basic_valid_drop", 32'(out_valid), 32'd0);
    chk("basic_idle_ready", 32'(in_ready), 32'd1);
    chk("basic_hold_rgb", {8'd0, out_r, out_g, out_b}, 32'h3CC366);
    chk("basic_busy_cycles", 32'(busy_cnt), 32'd5);

    run_pixel(16'h3C80);
    chk("scale_rgb", {8'd0, out_r, out_g, out_b}, 32'h1E6233);
    run_pixel(16'hFF00);
    chk("y0_rgb", {8'd0, out_r, out_g, out_b}, 32'h000000);
    run_pixel(16'h3C00);
    chk("raw_rgb", {8'd0, raw_r, raw_g, raw_b}, 32'h3CC366);

    // backpressure with a second pixel waiting
    acc0 = n_acc;
    cycle(1'b1, 16'h3CFF, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 16'h0180, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 16'h0180, 1'b0);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_rgb_stable", {8'd0, out_r, out_g, out_b}, 32'h3CC366);
    end
    cycle(1'b1, 16'h0180, 1'b1);
    cycle(1'b1, 16'h0180, 1'b1);
    chk("bp_second_accept", 32'(accepted), 32'd1);
    for (int k = 0; k < 6; k++) cycle(1'b0, 16'h0000, 1'b1);
    chk("bp_second_rgb", {8'd0, out_r, out_g, out_b}, 32'h007F2D);
    chk("bp_accept_count", 32'(n_acc - acc0), 32'd2);

    // async reset while capturing G
    cycle(1'b1, 16'h3CFF, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 16'h0000, 1'b1);
    chk("ar_pre_addr", 32'(rom_addr), 32'h23C);
    #2;
    resetl = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_rgb_zero", {8'd0, out_r, out_g, out_b}, 32'd0);
    chk("ar_rom_addr", 32'(rom_addr), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    exp_q.delete();
    exp_raw_q.delete();
    @(negedge sys_clk);
    @(negedge sys_clk);
    resetl = 1'b1;
    #1;
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    run_pixel(16'h3CFF);
    chk("ar_after_rgb", {8'd0, out_r, out_g, out_b}, 32'h3CC366);

    // back-to-back: 10 random pixels, out_ready high, 6 cycles each
    n_done = 0;
    sent = 0;
    cyc = 0;
    cur = 16'($urandom);
    while (n_done < 10 && cyc < 200) begin
      cycle(sent < 10, cur, 1'b1);
      cyc++;
      if (accepted) begin
        sent++;
        cur = 16'($urandom);
      end
    end
    chk("b2b_done", 32'(n_done), 32'd10);
    chk("b2b_cycles", 32'(cyc), 32'd60);

    // random handshakes on both sides
    n_done = 0;
    sent = 0;
    cyc = 0;
    while (n_done < 20 && cyc < 3000) begin
      cycle((sent < 20) && ($urandom_range(0, 1) == 1), 16'($urandom),
            $urandom_range(0, 3) != 0);
      cyc++;
      if (accepted) sent++;
    end
    chk("rand_done", 32'(n_done), 32'd20);

    cycle(1'b0, 16'h0000, 1'b1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("sb_raw_drained", 32'(exp_raw_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cry_rgb_lookup_seq.md
# cry_rgb_lookup_seq

Sequencer that converts one 16-bit CRY pixel into 24-bit RGB by time-sharing a single registered 256-entry-per-table colour ROM port. It performs three lookups (red, green and blue tables) and scales each result by the pixel's Y intensity. It sits between a CRY pixel source (line buffer / blitter path) and RGB consumers, replacing three parallel ROM instances with one shared port.

## Interface
- SCALE_EN, 1, 1 = scale the table value by Y; 0 = output the raw table value and ignore Y.
- sys_clk  in  1  sole clock; all state updates on its rising edge.
- resetl  in  1  asynchronous active-low reset.
- in_valid  in  1  CRY pixel offered.
- in_ready  out  1  block accepts the pixel this cycle.
- in_cry  in  16  [15:8] colour index (cyan/red nibbles), [7:0] Y intensity.
- rom_addr  out  10  registered ROM address {table[1:0], index[7:0]}; table 0 = R, 1 = G, 2 = B, 3 never driven.
- rom_q  in  8  ROM data; reflects the rom_addr that was present at the previous rising edge (1-cycle registered ROM).
- out_valid  out  1  RGB result held.
- out_ready  in  1  consumer takes the result.
- out_r, out_g, out_b  out  8 each  scaled colour components.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, A_R, A_G, C_R, C_G, OUT. A 3-bit step counter is an acceptable encoding, provided the behaviour is identical.
- Reset (async, while resetl = 0):
  - state = IDLE, rom_addr = 0, out_valid = 0, out_r/g/b = 0, busy = 0.
  - Internal index and Y latches = 0.
  - in_ready = 1 once state is IDLE.
- in_ready = (state == IDLE). The input is registered only when in_valid & in_ready.
- IDLE, on accept:
  - Latch index = in_cry[15:8] and Y = in_cry[7:0].
  - rom_addr <= {2'd0, index}; go to A_R.
- A_R: rom_addr <= {2'd1, index}; go to A_G.
- A_G:
  - rom_q holds the R value; capture scaled R.
  - rom_addr <= {2'd2, index}; go to C_R.
- C_R: rom_q holds the G value; capture scaled G; go to C_G.
- C_G: rom_q holds the B value; capture scaled B; out_valid <= 1; go to OUT.
- OUT:
  - out_r/g/b and out_valid are held stable while out_ready = 0.
  - On out_ready = 1: out_valid <= 0; go to IDLE.
  - out_r/g/b keep their last value after the transfer.
- rom_addr holds its last value outside the lookup states.
- Scaling (SCALE_EN = 1): comp = (lut * (Y + 1)) >> 8, unsigned.
  - lut is 8 bits; (Y + 1) is 9 bits, range 1..256; the product is 16 bits, max 65280, so no overflow.
  - Y = 0xFF returns lut exactly; Y = 0x00 returns 0.
- SCALE_EN = 0: comp = lut.
- in_valid while busy is ignored (in_ready = 0); no pixel is dropped or double-counted.

## Timing
- Accept at edge E0. rom_addr shows R/G/B addresses after E0/E1/E2. R/G/B are captured at E2/E3/E4.
- out_valid rises after E4, so latency is 4 cycles from the accept edge.
- Peak throughput is one pixel per 6 cycles with out_ready tied high: accept, four sequencing edges, output transfer, then IDLE.
- Reset mid-operation aborts immediately: no partial result, out_valid = 0, and the next accept restarts at R.
- in_valid and out_ready are sampled only on rising edges. There is no combinational path from in_valid or out_ready to any output except in_ready (which depends only on state).

## Test plan
Bench ROM model (1-cycle registered): R[i] = i, G[i] = ~i, B[i] = i ^ 0x5A.
- Basic, in_cry = 0x3CFF, out_ready = 1:
  - rom_addr sequence 0x03C, 0x13C, 0x23C.
  - After 4 cycles, out = R 0x3C, G 0xC3, B 0x66.
  - busy is high for 5 cycles.
- Scaling, in_cry = 0x3C80 -> R 0x1E, G 0x62, B 0x33.
- Y = 0, in_cry = 0xFF00 -> all components 0x00.
- SCALE_EN = 0, in_cry = 0x3C00 -> R 0x3C, G 0xC3, B 0x66.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles with in_valid = 1 and a second pixel 0x0180 offered.
  - Outputs stay stable and in_ready stays 0.
  - On release, the first pixel transfers, then 0x0180 is accepted -> R 0x00, G 0x7F, B 0x2D.
- Async reset:
  - Assert resetl = 0 in state C_R.
  - All outputs go to 0 immediately, without waiting for a clock edge, and in_ready = 1 after release.
  - The next pixel 0x3CFF completes with the correct values.
- Back-to-back pixels with out_ready = 1: 10 pixels finish in 60 cycles, each result matching the model.
